// File: rtl/csi2_pkg.sv
// Shared types and defaults for the CSI-2 lane delay calibration block.
package csi2_pkg;

    localparam int CSI2_TAPS_DEFAULT = 32;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        MEASURE,
        STEP,
        CENTER,
        NEXT_LANE,
        DONE
    } csi2_calib_state_t;

endpackage

// File: rtl/csi2_calib_run_tracker.sv
// Longest run of passing taps seen during one lane sweep; ties keep the earlier run.
module csi2_calib_run_tracker
    import csi2_pkg::*;
#(
    parameter int TAPS = CSI2_TAPS_DEFAULT
) (
    input  logic                      clk_i,
    input  logic                      srst_i,
    input  logic                      clear_i,
    input  logic                      valid_i,
    input  logic                      pass_i,
    input  logic [$clog2(TAPS)-1:0]   tap_i,
    output logic [$clog2(TAPS)-1:0]   best_start_o,
    output logic [$clog2(TAPS+1)-1:0] best_len_o
);

    localparam int TW = $clog2(TAPS);
    localparam int LNW = $clog2(TAPS + 1);

    logic [TW-1:0]  run_start_q;
    logic [TW-1:0]  run_start_nxt;
    logic [LNW-1:0] run_len_q;
    logic [LNW-1:0] run_len_nxt;
    logic [TW-1:0]  best_start_q;
    logic [LNW-1:0] best_len_q;

    always_comb begin
        run_start_nxt = (run_len_q == '0) ? tap_i : run_start_q;
        run_len_nxt   = run_len_q + LNW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (srst_i || clear_i) begin
            run_start_q  <= '0;
            run_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
        end else if (valid_i) begin
            if (pass_i) begin
                run_start_q <= run_start_nxt;
                run_len_q   <= run_len_nxt;
                // strictly longer only, so an equal later run never displaces the first
                if (run_len_nxt > best_len_q) begin
                    best_start_q <= run_start_nxt;
                    best_len_q   <= run_len_nxt;
                end
            end else begin
                run_len_q <= '0;
            end
        end
    end

    assign best_start_o = best_start_q;
    assign best_len_o   = best_len_q;

endmodule

// File: rtl/csi2_delay_calib.sv
// Per-lane D-PHY delay tap sweep and centring driven by CSI-2 header ECC results.
// Optional window timeout enabled by defining CSI2_CALIB_TIMEOUT_EN.
//   state     | meaning
//   IDLE      | waiting for start_i
//   SETTLE    | let the PHY settle after a tap change, packets ignored
//   MEASURE   | count packets/errors for the current tap
//   STEP      | pulse inc_delay_o for the active lane
//   CENTER    | walk the tap to the middle of the best run (1 high, 3 low)
//   NEXT_LANE | advance to the next lane or finish
//   DONE      | one-cycle completion pulse
module csi2_delay_calib
    import csi2_pkg::*;
#(
    parameter int DATA_LANES     = 2,
    parameter int TAPS           = CSI2_TAPS_DEFAULT,
    parameter int WINDOW_PKTS    = 16,
    parameter int SETTLE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                                     clk_i,
    input  logic                                     srst_i,
    input  logic                                     start_i,
    input  logic                                     pkt_ok_i,
    input  logic                                     pkt_err_i,
    output logic [DATA_LANES-1:0]                    inc_delay_o,
    output logic                                     busy_o,
    output logic                                     done_o,
    output logic [DATA_LANES-1:0]                    lane_fail_o,
    output logic [DATA_LANES-1:0][$clog2(TAPS)-1:0]  tap_o
);

    localparam int TW  = $clog2(TAPS);
    localparam int LNW = $clog2(TAPS + 1);
    localparam int LW  = (DATA_LANES > 1) ? $clog2(DATA_LANES) : 1;
    localparam int PW  = $clog2(WINDOW_PKTS + 2);
    localparam int SW  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    csi2_calib_state_t state_q, state_nxt;

    logic [LW-1:0]                   lane_q;
    logic [DATA_LANES-1:0][TW-1:0]   tap_q;
    logic [DATA_LANES-1:0]           fail_q;
    logic [TW-1:0]                   sweep_q;
    logic [SW-1:0]                   settle_q;
    logic [PW-1:0]                   pkt_q;
    logic [PW-1:0]                   err_q;
    logic [TW-1:0]                   ctr_rem_q;
    logic [1:0]                      ph_q;

    logic [PW-1:0]  pkt_nxt;
    logic [PW-1:0]  err_nxt;
    logic           win_close;
    logic           timeout_hit;
    logic           start_ok;
    logic           last_lane;
    logic           last_step;
    logic [TW-1:0]  cur_tap;
    logic [TW-1:0]  tap_inc;
    logic [TW-1:0]  best_start;
    logic [LNW-1:0] best_len;
    logic [TW:0]    tsum;
    logic [TW:0]    tdiff;
    logic [TW-1:0]  target;
    logic [TW-1:0]  ctr_pulses;

    always_comb begin
        start_ok  = (state_q == IDLE) && start_i;
        last_lane = (lane_q == LW'(DATA_LANES - 1));
        last_step = (sweep_q == TW'(TAPS - 1));
        cur_tap   = tap_q[lane_q];
        tap_inc   = (cur_tap == TW'(TAPS - 1)) ? '0 : cur_tap + TW'(1);
        pkt_nxt   = pkt_q + PW'(pkt_ok_i) + PW'(pkt_err_i);
        err_nxt   = err_q + PW'(pkt_err_i);
        win_close = (state_q == MEASURE) && (pkt_nxt >= PW'(WINDOW_PKTS));

        tsum   = {1'b0, best_start} + {1'b0, TW'(best_len >> 1)};
        target = (tsum >= (TW+1)'(TAPS)) ? TW'(tsum - (TW+1)'(TAPS)) : TW'(tsum);
        if (best_len == '0) begin
            target = '0;
        end
        // evaluated in STEP, so distance is measured from the post-step tap
        tdiff = {1'b0, target} - {1'b0, tap_inc};
        if (target < tap_inc) begin
            tdiff = tdiff + (TW+1)'(TAPS);
        end
        ctr_pulses = TW'(tdiff);
    end

`ifdef CSI2_CALIB_TIMEOUT_EN
    localparam int OW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [OW-1:0] to_q;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            to_q <= '0;
        end else if (state_q == SETTLE) begin
            to_q <= OW'(TIMEOUT_CYCLES - 1);
        end else if (state_q == MEASURE && to_q != '0) begin
            to_q <= to_q - OW'(1);
        end
    end

    assign timeout_hit = (state_q == MEASURE) && (to_q == '0);
`else
    assign timeout_hit = 1'b0;
`endif

    csi2_calib_run_tracker #(
        .TAPS (TAPS)
    ) u_run_tracker (
        .clk_i        (clk_i),
        .srst_i       (srst_i),
        .clear_i      (start_ok || (state_q == NEXT_LANE)),
        .valid_i      (win_close || timeout_hit),
        .pass_i       (win_close && (err_nxt == '0)),
        .tap_i        (cur_tap),
        .best_start_o (best_start),
        .best_len_o   (best_len)
    );

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state_q;
        inc_delay_o = '0;
        done_o      = 1'b0;
        busy_o      = (state_q != IDLE) && (state_q != DONE);
        case (state_q)
            IDLE:      if (start_i) state_nxt = SETTLE;
            SETTLE:    if (settle_q == '0) state_nxt = MEASURE;
            MEASURE:   if (win_close || timeout_hit) state_nxt = STEP;
            STEP: begin
                inc_delay_o[lane_q] = 1'b1;
                state_nxt = last_step ? CENTER : SETTLE;
            end
            CENTER: begin
                if (ph_q == 2'd3) inc_delay_o[lane_q] = 1'b1;
                if (ph_q == 2'd0 && ctr_rem_q == '0) state_nxt = NEXT_LANE;
            end
            NEXT_LANE: state_nxt = last_lane ? DONE : SETTLE;
            DONE: begin
                done_o    = 1'b1;
                state_nxt = IDLE;
            end
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            lane_q    <= '0;
            tap_q     <= '0;
            fail_q    <= '0;
            sweep_q   <= '0;
            settle_q  <= '0;
            pkt_q     <= '0;
            err_q     <= '0;
            ctr_rem_q <= '0;
            ph_q      <= '0;
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    fail_q   <= '0;
                    lane_q   <= '0;
                    sweep_q  <= '0;
                    settle_q <= SW'(SETTLE_CYCLES - 1);
                end
                SETTLE: begin
                    if (settle_q != '0) begin
                        settle_q <= settle_q - SW'(1);
                    end else begin
                        pkt_q <= '0;
                        err_q <= '0;
                    end
                end
                MEASURE: begin
                    pkt_q <= pkt_nxt;
                    err_q <= err_nxt;
                end
                STEP: begin
                    tap_q[lane_q] <= tap_inc;
                    if (last_step) begin
                        sweep_q   <= '0;
                        ctr_rem_q <= ctr_pulses;
                        ph_q      <= '0;
                        if (best_len == '0) fail_q[lane_q] <= 1'b1;
                    end else begin
                        sweep_q  <= sweep_q + TW'(1);
                        settle_q <= SW'(SETTLE_CYCLES - 1);
                    end
                end
                CENTER: if (!(ph_q == 2'd0 && ctr_rem_q == '0)) begin
                    ph_q <= ph_q + 2'd1;
                    if (ph_q == 2'd3) begin
                        tap_q[lane_q] <= tap_inc;
                        ctr_rem_q     <= ctr_rem_q - TW'(1);
                    end
                end
                NEXT_LANE: if (!last_lane) begin
                    lane_q   <= lane_q + LW'(1);
                    sweep_q  <= '0;
                    settle_q <= SW'(SETTLE_CYCLES - 1);
                end
                default: ;
            endcase
        end
    end

    assign tap_o       = tap_q;
    assign lane_fail_o = fail_q;

endmodule
